// File: rtl/line_clear_controller_if.sv
// Bus bundle between the line-clear controller, the game FSM and the external row eliminator.
// Board vectors are [0:199]: row r occupies bits r*10..r*10+9, row 0 at the bottom.
interface line_clear_controller_if;
  // start is a one-cycle request honoured only while busy is low (no ready path);
  // done is the matching one-cycle completion strobe, board_out/lines valid from then on.
  logic         start;
  logic [0:199] board_in;
  logic [0:199] elim_static;
  logic         elim_hit;
  logic [0:199] elim_result;
  logic         busy;
  logic         done;
  logic [0:199] board_out;
  logic [2:0]   lines;
  logic [15:0]  total_lines;
  logic [19:0]  score;

  modport slave (
    input  start, board_in, elim_hit, elim_result,
    output elim_static, busy, done, board_out, lines, total_lines, score
  );

  modport master (
    output start, board_in, elim_hit, elim_result,
    input  elim_static, busy, done, board_out, lines, total_lines, score
  );
endinterface

// File: rtl/line_clear_controller.sv
// Line-clear sequencer: repeatedly feeds the working board to the row eliminator until no full row remains.
// Optional scoring is enabled by defining LINE_CLEAR_SCORE_EN; otherwise score is tied to 0.
module line_clear_controller #(
  parameter int MAX_ROWS    = 4,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  line_clear_controller_if.slave  bus,
  output logic [2:0]              o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // The hold counter loads HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES cycles.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

  state_t         r_state;
  logic [0:199]   r_work;
  logic [2:0]     r_count;
  logic [HW-1:0]  r_hold;
  logic           r_busy;
  logic           r_done;
  logic [0:199]   r_board_out;
  logic [2:0]     r_lines;
  logic [15:0]    r_total;

  logic           w_take;
  logic           w_finish;
  logic [16:0]    w_total_sum;

  assign w_take      = bus.elim_hit && (r_count < 3'(MAX_ROWS));
  assign w_finish    = (r_state == S_CHECK) && !w_take;
  assign w_total_sum = {1'b0, r_total} + {14'd0, r_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_count     <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_board_out <= '0;
      r_lines     <= '0;
      r_total     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work  <= bus.board_in;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_take) begin
            r_state <= S_WAIT;
          end else begin
            r_board_out <= r_work;
            r_lines     <= r_count;
            r_total     <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
            r_done      <= 1'b1;
            r_state     <= S_FINISH;
          end
        end
        S_WAIT: begin
          // The eliminator registered its result on the CHECK->WAIT edge.
          r_work  <= bus.elim_result;
          r_count <= r_count + 3'd1;
          if (HOLD_CYCLES > 0) begin
            r_hold  <= HOLD_INIT;
            r_state <= S_HOLD;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_HOLD: begin
          if (r_hold == '0) r_state <= S_CHECK;
          else              r_hold  <= r_hold - 1'b1;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0] r_score;
  logic [19:0] w_points;
  logic [19:0] w_score_sum;

  always_comb begin
    w_points = 20'd0;
    case (r_count)
      3'd0:    w_points = 20'd0;
      3'd1:    w_points = 20'd100;
      3'd2:    w_points = 20'd300;
      3'd3:    w_points = 20'd500;
      default: w_points = 20'd800;
    endcase
  end

  // 999999 + 800 still fits in 20 bits, so the sum cannot wrap before the clamp.
  assign w_score_sum = r_score + w_points;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else if (w_finish) begin
      r_score <= (w_score_sum > 20'd999999) ? 20'd999999 : w_score_sum;
    end
  end

  assign bus.score = r_score;
`else
  assign bus.score = '0;
`endif

  assign bus.elim_static = r_work;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.board_out   = r_board_out;
  assign bus.lines       = r_lines;
  assign bus.total_lines = r_total;
  assign o_state         = r_state;

endmodule

// File: tb/tb_line_clear_controller.sv
// Directed bench for line_clear_controller: default DUT plus a HOLD_CYCLES=3 instance,
// each paired with a behavioural row eliminator.
module tb_line_clear_controller;

`ifdef LINE_CLEAR_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [2:0] m_state;
  logic [2:0] h_state;
  int n_cmp;
  int n_fail;

  line_clear_controller_if m_if ();
  line_clear_controller_if h_if ();

  line_clear_controller u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (m_if),
    .o_state (m_state)
  );

  line_clear_controller #(.HOLD_CYCLES(3)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .bus     (h_if),
    .o_state (h_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- eliminator model ----------------
  function automatic logic full_any(input logic [0:199] b);
    logic f;
    f = 1'b0;
    for (int row = 0; row < 20; row++) if (&b[row*10 +: 10]) f = 1'b1;
    return f;
  endfunction

  function automatic logic [0:199] compact(input logic [0:199] b);
    logic [0:199] r;
    int low;
    low = -1;
    for (int row = 0; row < 20; row++) if (low < 0 && (&b[row*10 +: 10])) low = row;
    r = b;
    if (low >= 0) begin
      for (int i = low * 10; i < 200; i++) begin
        if (i < 190) r[i] = b[i+10];
        else         r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  assign m_if.elim_hit = full_any(m_if.elim_static);
  assign h_if.elim_hit = full_any(h_if.elim_static);
  always @(posedge clk) m_if.elim_result <= compact(m_if.elim_static);
  always @(posedge clk) h_if.elim_result <= compact(h_if.elim_static);

  // ---------------- driver ----------------
  // Accept edge = cycle 0; done "in cycle c" means done is high just before edge c.
  task automatic run_op(input bit sel, input logic [0:199] b, input int start_until,
                        output int done_cyc, output int n_done, output int busy_drop);
    logic d;
    logic bz;
    @(negedge clk);
    if (sel) begin h_if.start = 1'b1; h_if.board_in = b; end
    else     begin m_if.start = 1'b1; m_if.board_in = b; end
    @(posedge clk);
    #1;
    if (start_until == 0) begin h_if.start = 1'b0; m_if.start = 1'b0; end
    done_cyc = -1; n_done = 0; busy_drop = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      d  = sel ? h_if.done : m_if.done;
      bz = sel ? h_if.busy : m_if.busy;
      if (d) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!bz && done_cyc < 0 && busy_drop == 0) busy_drop = c;
      if (c > start_until) begin h_if.start = 1'b0; m_if.start = 1'b0; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    m_if.start = 1'b0; m_if.board_in = '0;
    h_if.start = 1'b0; h_if.board_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", m_if.busy); end
    n_cmp++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", m_if.done); end
    n_cmp++; if (m_if.board_out !== 200'd0) begin n_fail++; $display("FAIL reset_board_out got=%h want=0", m_if.board_out); end
    n_cmp++; if (m_if.elim_static !== 200'd0) begin n_fail++; $display("FAIL reset_elim_static got=%h want=0", m_if.elim_static); end
    n_cmp++; if (m_if.lines !== 3'd0) begin n_fail++; $display("FAIL reset_lines got=%0d want=0", m_if.lines); end
    n_cmp++; if (m_if.total_lines !== 16'd0) begin n_fail++; $display("FAIL reset_total got=%0d want=0", m_if.total_lines); end
    n_cmp++; if (m_if.score !== 20'd0) begin n_fail++; $display("FAIL reset_score got=%0d want=0", m_if.score); end
    n_cmp++; if (m_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", m_state); end
  endtask

  task automatic test_empty();
    int dc, nd, bd;
    run_op(1'b0, '0, 0, dc, nd, bd);
    n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL empty_done_cycle got=%0d want=2", dc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL empty_done_pulses got=%0d want=1", nd); end
    n_cmp++; if (m_if.lines !== 3'd0) begin n_fail++; $display("FAIL empty_lines got=%0d want=0", m_if.lines); end
    n_cmp++; if (m_if.board_out !== 200'd0) begin n_fail++; $display("FAIL empty_board got=%h want=0", m_if.board_out); end
    n_cmp++; if (m_if.total_lines !== 16'd0) begin n_fail++; $display("FAIL empty_total got=%0d want=0", m_if.total_lines); end
    n_cmp++; if (m_if.score !== 20'd0) begin n_fail++; $display("FAIL empty_score got=%0d want=0", m_if.score); end
  endtask

  task automatic test_single_row();
    logic [0:199] b, e;
    int dc, nd, bd;
    b = '0; for (int i = 0; i < 10; i++) b[i] = 1'b1; b[15] = 1'b1;
    e = '0; e[5] = 1'b1;
    // Spot-check that the snapshot is presented to the eliminator during CHECK.
    @(negedge clk);
    m_if.start = 1'b1; m_if.board_in = b;
    @(posedge clk); #1 m_if.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_if.elim_static !== b) begin n_fail++; $display("FAIL single_snapshot got=%h want=%h", m_if.elim_static, b); end
    repeat (6) @(negedge clk);
    n_cmp++; if (m_if.board_out !== e) begin n_fail++; $display("FAIL single_board_a got=%h want=%h", m_if.board_out, e); end
    // Same board again through the timed driver; totals accumulate.
    run_op(1'b0, b, 0, dc, nd, bd);
    n_cmp++; if (dc !== 4) begin n_fail++; $display("FAIL single_done_cycle got=%0d want=4", dc); end
    n_cmp++; if (m_if.lines !== 3'd1) begin n_fail++; $display("FAIL single_lines got=%0d want=1", m_if.lines); end
    n_cmp++; if (m_if.board_out !== e) begin n_fail++; $display("FAIL single_board got=%h want=%h", m_if.board_out, e); end
    n_cmp++; if (m_if.total_lines !== 16'd2) begin n_fail++; $display("FAIL single_total got=%0d want=2", m_if.total_lines); end
    n_cmp++; if (m_if.score !== (SCORE_EN ? 20'd200 : 20'd0)) begin n_fail++; $display("FAIL single_score got=%0d want=%0d", m_if.score, SCORE_EN ? 200 : 0); end
  endtask

  task automatic test_four_rows();
    logic [0:199] b, e;
    int dc, nd, bd;
    b = '0; for (int i = 0; i < 41; i++) b[i] = 1'b1;
    e = '0; e[0] = 1'b1;
    run_op(1'b0, b, 0, dc, nd, bd);
    n_cmp++; if (dc !== 10) begin n_fail++; $display("FAIL four_done_cycle got=%0d want=10", dc); end
    n_cmp++; if (m_if.lines !== 3'd4) begin n_fail++; $display("FAIL four_lines got=%0d want=4", m_if.lines); end
    n_cmp++; if (m_if.board_out !== e) begin n_fail++; $display("FAIL four_board got=%h want=%h", m_if.board_out, e); end
    n_cmp++; if (m_if.total_lines !== 16'd6) begin n_fail++; $display("FAIL four_total got=%0d want=6", m_if.total_lines); end
    n_cmp++; if (m_if.score !== (SCORE_EN ? 20'd1000 : 20'd0)) begin n_fail++; $display("FAIL four_score got=%0d want=%0d", m_if.score, SCORE_EN ? 1000 : 0); end
  endtask

  task automatic test_split_rows();
    logic [0:199] b, e;
    int dc, nd, bd;
    b = '0;
    for (int i = 20; i < 30; i++) b[i] = 1'b1;
    for (int i = 50; i < 60; i++) b[i] = 1'b1;
    b[70] = 1'b1; b[35] = 1'b1;
    e = '0; e[25] = 1'b1; e[50] = 1'b1;
    run_op(1'b0, b, 0, dc, nd, bd);
    n_cmp++; if (dc !== 6) begin n_fail++; $display("FAIL split_done_cycle got=%0d want=6", dc); end
    n_cmp++; if (m_if.lines !== 3'd2) begin n_fail++; $display("FAIL split_lines got=%0d want=2", m_if.lines); end
    n_cmp++; if (m_if.board_out !== e) begin n_fail++; $display("FAIL split_board got=%h want=%h", m_if.board_out, e); end
    n_cmp++; if (m_if.total_lines !== 16'd8) begin n_fail++; $display("FAIL split_total got=%0d want=8", m_if.total_lines); end
    n_cmp++; if (m_if.score !== (SCORE_EN ? 20'd1300 : 20'd0)) begin n_fail++; $display("FAIL split_score got=%0d want=%0d", m_if.score, SCORE_EN ? 1300 : 0); end
  endtask

  task automatic test_max_rows();
    logic [0:199] b, e;
    int dc, nd, bd;
    b = '0; for (int i = 0; i < 50; i++) b[i] = 1'b1;
    e = '0; for (int i = 0; i < 10; i++) e[i] = 1'b1;
    run_op(1'b0, b, 0, dc, nd, bd);
    n_cmp++; if (dc !== 10) begin n_fail++; $display("FAIL max_done_cycle got=%0d want=10", dc); end
    n_cmp++; if (m_if.lines !== 3'd4) begin n_fail++; $display("FAIL max_lines got=%0d want=4", m_if.lines); end
    n_cmp++; if (m_if.board_out !== e) begin n_fail++; $display("FAIL max_board got=%h want=%h", m_if.board_out, e); end
    n_cmp++; if (m_if.total_lines !== 16'd12) begin n_fail++; $display("FAIL max_total got=%0d want=12", m_if.total_lines); end
    n_cmp++; if (m_if.score !== (SCORE_EN ? 20'd2100 : 20'd0)) begin n_fail++; $display("FAIL max_score got=%0d want=%0d", m_if.score, SCORE_EN ? 2100 : 0); end
  endtask

  task automatic test_start_while_busy();
    logic [0:199] b;
    int dc, nd, bd;
    b = '0; for (int i = 0; i < 10; i++) b[i] = 1'b1;
    // start held through CHECK, WAIT, CHECK and FINISH.
    run_op(1'b0, b, 4, dc, nd, bd);
    n_cmp++; if (dc !== 4) begin n_fail++; $display("FAIL busy_start_done_cycle got=%0d want=4", dc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL busy_start_pulses got=%0d want=1", nd); end
    n_cmp++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got=%b want=0", m_if.busy); end
    n_cmp++; if (m_if.total_lines !== 16'd13) begin n_fail++; $display("FAIL busy_start_total got=%0d want=13", m_if.total_lines); end
  endtask

  task automatic test_reset_abort();
    logic [0:199] b;
    int nd;
    b = '0; for (int i = 0; i < 10; i++) b[i] = 1'b1;
    @(negedge clk);
    m_if.start = 1'b1; m_if.board_in = b;
    @(posedge clk); #1 m_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (m_state !== 3'd2) begin n_fail++; $display("FAIL abort_in_wait got=%0d want=2", m_state); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", m_if.busy); end
    n_cmp++; if (m_if.board_out !== 200'd0) begin n_fail++; $display("FAIL abort_board got=%h want=0", m_if.board_out); end
    n_cmp++; if (m_if.total_lines !== 16'd0) begin n_fail++; $display("FAIL abort_total got=%0d want=0", m_if.total_lines); end
    n_cmp++; if (m_if.lines !== 3'd0) begin n_fail++; $display("FAIL abort_lines got=%0d want=0", m_if.lines); end
    n_cmp++; if (m_if.score !== 20'd0) begin n_fail++; $display("FAIL abort_score got=%0d want=0", m_if.score); end
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_if.done) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d want=0", nd); end
  endtask

  task automatic test_hold();
    logic [0:199] b;
    int dc, nd, bd;
    b = '0; for (int i = 0; i < 10; i++) b[i] = 1'b1; b[12] = 1'b1;
    run_op(1'b1, b, 0, dc, nd, bd);
    n_cmp++; if (dc !== 7) begin n_fail++; $display("FAIL hold_done_cycle got=%0d want=7", dc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL hold_done_pulses got=%0d want=1", nd); end
    n_cmp++; if (bd !== 0) begin n_fail++; $display("FAIL hold_busy_gap got_cycle=%0d want=none", bd); end
    n_cmp++; if (h_if.lines !== 3'd1) begin n_fail++; $display("FAIL hold_lines got=%0d want=1", h_if.lines); end
    n_cmp++; if (h_if.board_out[2] !== 1'b1 || h_if.board_out[12] !== 1'b0) begin n_fail++; $display("FAIL hold_board got=%h want=bit2 only", h_if.board_out); end
    n_cmp++; if (h_if.score !== (SCORE_EN ? 20'd100 : 20'd0)) begin n_fail++; $display("FAIL hold_score got=%0d want=%0d", h_if.score, SCORE_EN ? 100 : 0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_empty();
    test_single_row();
    test_four_rows();
    test_split_rows();
    test_max_rows();
    test_start_while_busy();
    test_reset_abort();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
